// File: rtl/common.sv
// Shared data-bus types for the core and its memory responders.
// Holds the request/response bundles, access-size encoding and default base.
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam logic [63:0] DBUS_DEFAULT_BASE = 64'h8000_0000;

endpackage

// File: rtl/dbus_sram_array.sv
// DEPTH_WORDS x 64-bit storage: one byte-enabled synchronous write port
// and one registered read port. Contents are never reset.
// Ports: clk, we/be/waddr/wdata (write), re/raddr (read), rdata (read register).
module dbus_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: accepts one request at a time, does a byte-strobed
// 64-bit SRAM access at accept and answers data_ok LATENCY cycles later.
// Ports: clk; reset (async, active-low); dreq (request bundle);
//   dresp (addr_ok/data_ok/data); busy (request in flight); misalign.
// Optional: define DBUS_MISALIGN_CHECK_EN to flag and suppress accesses
//   whose address is not aligned to dreq.size.
module dbus_sram_responder
    import common::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = DBUS_DEFAULT_BASE
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        accept;
    logic [63:0] off;
    logic        in_range;
    logic        bad_align;
    logic        ok;
    logic        wr;
    logic        rd_ok_q;
    logic        mis_q;
    logic [63:0] rdata;
    logic        unused_ok;

    // addr_ok is gated by reset so it reads 0 while reset is held.
    assign accept = reset && (state == IDLE) && dreq.valid;

    // Range test on the full offset so addresses past the array never alias.
    assign off      = dreq.addr - BASE_ADDR;
    assign in_range = (dreq.addr >= BASE_ADDR)
                   && ({3'b000, off[63:3]} < 64'(DEPTH_WORDS));

`ifdef DBUS_MISALIGN_CHECK_EN
    always_comb begin
        bad_align = 1'b0;
        unique case (dreq.size)
            MSIZE2:  bad_align = dreq.addr[0];
            MSIZE4:  bad_align = |dreq.addr[1:0];
            MSIZE8:  bad_align = |dreq.addr[2:0];
            default: bad_align = 1'b0;
        endcase
    end
`else
    assign bad_align = 1'b0;
`endif

    assign ok        = in_range && !bad_align;
    assign wr        = |dreq.strobe;
    assign unused_ok = ^{off[2:0], dreq.size};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Remembers whether the in-flight request returns array data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ok_q <= 1'b0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            rd_ok_q <= ok && !wr;
            mis_q   <= bad_align;
        end
    end

    dbus_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (accept && ok && wr),
        .be    (dreq.strobe),
        .waddr (off[3 +: AW]),
        .wdata (dreq.data),
        .re    (accept && ok && !wr),
        .raddr (off[3 +: AW]),
        .rdata (rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = accept;
        dresp.data_ok = (state == RESP);
        if ((state == RESP) && rd_ok_q) dresp.data = rdata;
    end

    assign busy     = (state != IDLE);
    assign misalign = mis_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 2, 1, 5)
// checked every cycle against a transaction-level model, plus literal cases.
module tb_dbus_sram_responder;
    import common::*;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef DBUS_MISALIGN_CHECK_EN
    localparam bit MCHK = 1'b1;
`else
    localparam bit MCHK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    dbus_req_t  dreq_a  [3];
    dbus_resp_t dresp_a [3];
    logic [2:0] busy_v;
    logic [2:0] mis_v;

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_sram_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 5)),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .dreq     (dreq_a[g]),
            .dresp    (dresp_a[g]),
            .busy     (busy_v[g]),
            .misalign (mis_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    function automatic bit mis_of(input logic [63:0] a, input msize_t s);
        case (s)
            MSIZE2:  return a[0];
            MSIZE4:  return |a[1:0];
            MSIZE8:  return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Instance i is busy in cycles acc+1 .. acc+L and answers at acc+L;
    // it accepts in any other cycle where valid is high.
    int          cyc = 0;
    int          acc  [3] = '{-1, -1, -1};
    logic [63:0] rexp [3];
    logic        mexp [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] mm   [3][16];

    task automatic capture(input int i);
        logic [63:0] a, off;
        bit          inr, mis, okk;
        int          idx;
        a    = dreq_a[i].addr;
        off  = a - BASE;
        inr  = (a >= BASE) && ((off >> 3) < 64'(DEPTH));
        mis  = MCHK && mis_of(a, dreq_a[i].size);
        okk  = inr && !mis;
        idx  = inr ? int'(off >> 3) : 0;
        mexp[i] = mis;
        if (dreq_a[i].strobe != 8'h00) begin
            rexp[i] = 64'h0;
            if (okk && idx < 16)
                for (int b = 0; b < 8; b++)
                    if (dreq_a[i].strobe[b])
                        mm[i][idx][8*b +: 8] = dreq_a[i].data[8*b +: 8];
        end else begin
            rexp[i] = (okk && idx < 16) ? mm[i][idx] : 64'h0;
        end
    endtask

    initial begin
        int d;
        bit inw, rsp, aok;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                d   = cyc - acc[i];
                inw = (acc[i] >= 0) && (d >= 1) && (d <= lat(i));
                rsp = (acc[i] >= 0) && (d == lat(i));
                aok = !inw && dreq_a[i].valid;
                if (!reset) begin
                    inw = 0; rsp = 0; aok = 0;
                    acc[i] = -1; mexp[i] = 1'b0;
                end
                chk($sformatf("dut%0d addr_ok", i), 64'(dresp_a[i].addr_ok), 64'(aok));
                chk($sformatf("dut%0d data_ok", i), 64'(dresp_a[i].data_ok), 64'(rsp));
                chk($sformatf("dut%0d data", i), dresp_a[i].data, rsp ? rexp[i] : 64'h0);
                chk($sformatf("dut%0d busy", i), 64'(busy_v[i]), 64'(inw));
                chk($sformatf("dut%0d misalign", i), 64'(mis_v[i]), 64'(mexp[i]));
                if (aok) begin
                    acc[i] = cyc;
                    capture(i);
                end
            end
            cyc++;
        end
    end

    function automatic bit any_busy();
        for (int i = 0; i < 3; i++)
            if (acc[i] >= 0 && cyc - acc[i] >= 1 && cyc - acc[i] <= lat(i))
                return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic set_all(input dbus_req_t r);
        for (int i = 0; i < 3; i++) dreq_a[i] = r;
    endtask

    task automatic set_valid(input logic v);
        for (int i = 0; i < 3; i++) dreq_a[i].valid = v;
    endtask

    // Called at posedge+1 with all instances idle; returns likewise.
    task automatic xfer(input logic [63:0] a, input msize_t sz,
                        input logic [7:0] sb, input logic [63:0] dd,
                        input logic [63:0] expd, input bit cd);
        dbus_req_t   r;
        int          dok [3];
        logic [63:0] got [3];
        r = '{valid: 1'b1, addr: a, size: sz, strobe: sb, data: dd};
        set_all(r);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("xfer dut%0d accept", i), 64'(dresp_a[i].addr_ok), 64'd1);
        @(posedge clk); #1;
        set_valid(1'b0);
        for (int i = 0; i < 3; i++) begin dok[i] = -1; got[i] = '0; end
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (dresp_a[i].data_ok && dok[i] < 0) begin
                    dok[i] = t;
                    got[i] = dresp_a[i].data;
                end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("xfer dut%0d latency", i), 64'(dok[i]), 64'(lat(i)));
            if (cd) chk($sformatf("xfer dut%0d rdata", i), got[i], expd);
        end
    endtask

    task automatic wait_free();
        int g;
        g = 0;
        while (any_busy() && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 30) chk("wait_free timeout", 64'(g), 64'd0);
    endtask

    task automatic rst_pulse_check(input string tag);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s dut%0d busy", tag, i), 64'(busy_v[i]), 64'd0);
            chk($sformatf("%s dut%0d data_ok", tag, i), 64'(dresp_a[i].data_ok), 64'd0);
            chk($sformatf("%s dut%0d data", tag, i), dresp_a[i].data, 64'h0);
        end
        set_valid(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dbus_req_t r;
        int        hold;
        int        sel;
        int        seen;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) dreq_a[i] = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // quiet bus after reset
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("idle dut%0d", i),
                    {61'b0, busy_v[i], dresp_a[i].addr_ok, dresp_a[i].data_ok}, 64'd0);
        end
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++)
            xfer(BASE + 64'(8 * w), MSIZE8, 8'hFF,
                 64'hA5A5_0000_0000_0000 | 64'(w), 64'h0, 1'b1);

        xfer(BASE + 64'd8, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b1);
        xfer(BASE + 64'd8, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1);

        xfer(BASE + 64'd11, MSIZE1, 8'h08, 64'hAB << 24, 64'h0, 1'b1);
        xfer(BASE + 64'd8, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_AB66_7788, 1'b1);

        xfer(BASE, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 1'b1);
        xfer(BASE + 64'(8 * DEPTH), MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        xfer(BASE + 64'(8 * DEPTH), MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1);
        xfer(BASE - 64'd8, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1);
        xfer(BASE, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);

        xfer(BASE + 64'd2, MSIZE4, 8'h00, 64'h0,
             MCHK ? 64'h0 : 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("misalign flag dut%0d", i), 64'(mis_v[i]), 64'(MCHK));

        // reset while LATENCY 2/5 instances wait
        r = '{valid: 1'b1, addr: BASE + 64'd8, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        set_all(r);
        @(posedge clk); #1;
        rst_pulse_check("rst_wait");
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            seen += int'(dresp_a[0].data_ok) + int'(dresp_a[1].data_ok)
                  + int'(dresp_a[2].data_ok);
        end
        chk("no data_ok after reset", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            r.valid = 1'b1;
            if (sel == 0)
                r.addr = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 7));
            else if (sel == 1)
                r.addr = BASE - 64'd8 + 64'($urandom_range(0, 7));
            else
                r.addr = BASE + 64'(8 * $urandom_range(0, 15))
                       + 64'($urandom_range(0, 7));
            r.size = msize_t'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                2:       r.strobe = 8'hFF;
                3:       r.strobe = 8'($urandom);
                default: r.strobe = 8'h00;
            endcase
            r.data = {$urandom, $urandom};
            set_all(r);
            if ($urandom_range(0, 9) == 0) begin
                rst_pulse_check("rst_rand");
            end else begin
                hold = $urandom_range(1, 12);
                repeat (hold) begin @(posedge clk); #1; end
                set_valid(1'b0);
            end
            wait_free();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
